// File: rtl/ef_gpio8_irq_if.sv
// rtl/ef_gpio8_irq_if.sv - pin event flags, status and counter access bundle for ef_gpio8_irq
interface ef_gpio8_irq_if #(
  parameter int CNT_W = 8
);
  logic [7:0]       pin_hi;
  logic [7:0]       pin_lo;
  logic [7:0]       pin_pe;
  logic [7:0]       pin_ne;
  logic [15:0]      ev_sel;
  logic [7:0]       im;
  logic [7:0]       icr;
  logic [7:0]       ris;
  logic [7:0]       mis;
  logic             irq;
  logic [2:0]       cnt_sel;
  logic             cnt_clr;
  logic [CNT_W-1:0] cnt_val;

  modport master (
    output pin_hi, pin_lo, pin_pe, pin_ne, ev_sel, im, icr, cnt_sel, cnt_clr,
    input  ris, mis, irq, cnt_val
  );

  modport slave (
    input  pin_hi, pin_lo, pin_pe, pin_ne, ev_sel, im, icr, cnt_sel, cnt_clr,
    output ris, mis, irq, cnt_val
  );
endinterface

// File: rtl/ef_gpio8_irq.sv
// rtl/ef_gpio8_irq.sv - per-pin event select, sticky status, masked irq and saturating event counters
module ef_gpio8_irq #(
  parameter int CNT_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  ef_gpio8_irq_if.slave bus
);
  logic [7:0]       ev;
  logic [7:0]       ris_q, ris_d;
  logic             irq_q;
  logic [CNT_W-1:0] cnt_q [8];
  logic [CNT_W-1:0] cnt_d [8];

  always_comb begin
    ev = '0;
    for (int i = 0; i < 8; i++) begin
      case (bus.ev_sel[2*i +: 2])
        2'b00:   ev[i] = bus.pin_hi[i];
        2'b01:   ev[i] = bus.pin_lo[i];
        2'b10:   ev[i] = bus.pin_pe[i];
        default: ev[i] = bus.pin_ne[i];
      endcase
    end
  end

  // A new event wins over a same-cycle write-one-to-clear.
  always_comb begin
    ris_d = ris_q;
    for (int i = 0; i < 8; i++) begin
      if (ev[i])
        ris_d[i] = 1'b1;
      else if (bus.icr[i])
        ris_d[i] = 1'b0;
    end
  end

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      cnt_d[i] = cnt_q[i];
      if (bus.cnt_clr && (bus.cnt_sel == 3'(i)))
        cnt_d[i] = ev[i] ? CNT_W'(1) : '0;
      else if (ev[i] && (cnt_q[i] != '1))
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ris_q <= '0;
      irq_q <= 1'b0;
      for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
    end else begin
      ris_q <= ris_d;
      irq_q <= |(ris_q & bus.im);
      for (int i = 0; i < 8; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign bus.ris     = ris_q;
  assign bus.mis     = ris_q & bus.im;
  assign bus.irq     = irq_q;
  assign bus.cnt_val = cnt_q[bus.cnt_sel];
endmodule

// File: tb/tb_ef_gpio8_irq.sv
// tb/tb_ef_gpio8_irq.sv - directed stimulus with an event-rule reference model checked every cycle
module tb_ef_gpio8_irq;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  ef_gpio8_irq_if #(.CNT_W(CNT_W)) bus ();
  ef_gpio8_irq #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // reference state
  bit [7:0] m_ris;
  bit       m_irq;
  int       m_cnt [8];

  always @(posedge clk) begin
    bit [7:0] src [4];
    bit       e;
    int       kind;
    if (rst) begin
      m_ris = 0;
      m_irq = 0;
      for (int p = 0; p < 8; p++) m_cnt[p] = 0;
    end else begin
      m_irq = ((m_ris & bus.im) != 0);
      src[0] = bus.pin_hi; src[1] = bus.pin_lo; src[2] = bus.pin_pe; src[3] = bus.pin_ne;
      for (int p = 0; p < 8; p++) begin
        kind = (int'(bus.ev_sel) >> (2 * p)) % 4;
        e = src[kind][p];
        if (e) m_ris[p] = 1;
        else if (bus.icr[p]) m_ris[p] = 0;
        if (bus.cnt_clr && int'(bus.cnt_sel) == p) m_cnt[p] = e ? 1 : 0;
        else if (e) m_cnt[p] = (m_cnt[p] + 1 > CMAX) ? CMAX : m_cnt[p] + 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("model_ris", 32'(bus.ris), 32'(m_ris));
      chk("model_mis", 32'(bus.mis), 32'(m_ris & bus.im));
      chk("model_irq", 32'(bus.irq), 32'(m_irq));
      chk("model_cnt", 32'(bus.cnt_val), 32'(m_cnt[bus.cnt_sel]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.pin_hi = 0; bus.pin_lo = 0; bus.pin_pe = 0; bus.pin_ne = 0;
    bus.icr = 0; bus.cnt_clr = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    bus.ev_sel = 0; bus.im = 0; bus.cnt_sel = 0;
    rst = 1;
    tick();
    rst = 0;
  endtask

  initial begin
    rst = 1;
    bus.pin_hi = 8'hFF; bus.pin_lo = 8'hFF; bus.pin_pe = 8'hFF; bus.pin_ne = 8'hFF;
    bus.ev_sel = 0; bus.im = 0; bus.icr = 0; bus.cnt_sel = 0; bus.cnt_clr = 0;
    tick();
    tick();
    chk("rst_ris", 32'(bus.ris), 0);
    chk("rst_irq", 32'(bus.irq), 0);
    chk("rst_cnt", 32'(bus.cnt_val), 0);
    rst = 0;
    tick();
    chk("first_ris", 32'(bus.ris), 32'hFF);
    chk("first_cnt", 32'(bus.cnt_val), 1);

    // rising edge on pin 3
    do_reset();
    bus.ev_sel = 16'h0080; bus.im = 8'h08;
    bus.pin_pe = 8'h08;
    tick();
    bus.pin_pe = 0;
    chk("pe_ris", 32'(bus.ris), 32'h08);
    chk("pe_irq_n", 32'(bus.irq), 0);
    tick();
    chk("pe_irq", 32'(bus.irq), 1);
    bus.icr = 8'h08;
    tick();
    bus.icr = 0;
    chk("icr_ris", 32'(bus.ris), 0);
    chk("icr_irq_lag", 32'(bus.irq), 1);
    tick();
    chk("icr_irq", 32'(bus.irq), 0);
    bus.cnt_sel = 3;
    #1;
    chk("pe_cnt", 32'(bus.cnt_val), 1);

    // set wins over clear on pin 5
    do_reset();
    bus.ev_sel = 16'h0C00;
    bus.pin_ne = 8'h20; bus.icr = 8'h20;
    tick();
    idle_inputs();
    chk("collide_ris", 32'(bus.ris), 32'h20);

    // level-high on pin 0, masked
    do_reset();
    bus.pin_hi = 8'h01;
    repeat (4) tick();
    chk("lvl_ris", 32'(bus.ris), 32'h01);
    chk("lvl_mis", 32'(bus.mis), 0);
    chk("lvl_irq", 32'(bus.irq), 0);
    chk("lvl_cnt", 32'(bus.cnt_val), 4);
    bus.icr = 8'h01;
    tick();
    chk("lvl_icr_held", 32'(bus.ris), 32'h01);
    bus.pin_hi = 0; bus.icr = 0;
    tick();
    chk("lvl_hold", 32'(bus.ris), 32'h01);
    bus.icr = 8'h01;
    tick();
    bus.icr = 0;
    chk("lvl_clr", 32'(bus.ris), 0);

    // saturation and clear on pin 7
    do_reset();
    bus.ev_sel = 16'h8000; bus.cnt_sel = 7;
    for (int i = 0; i < 20; i++) begin
      bus.pin_pe = 8'h80;
      tick();
      if (i == 2) chk("cnt_consec", 32'(bus.cnt_val), 3);
    end
    bus.pin_pe = 0;
    chk("cnt_sat", 32'(bus.cnt_val), 15);
    bus.cnt_clr = 1; bus.pin_pe = 8'h80;
    tick();
    bus.pin_pe = 0;
    chk("cnt_clr_ev", 32'(bus.cnt_val), 1);
    tick();
    bus.cnt_clr = 0;
    chk("cnt_clr", 32'(bus.cnt_val), 0);

    // multi-pin, then reset overriding events
    do_reset();
    bus.ev_sel = 16'hAAAA; bus.im = 8'h01;
    bus.pin_pe = 8'hA5;
    tick();
    bus.pin_pe = 0;
    chk("multi_ris", 32'(bus.ris), 32'hA5);
    chk("multi_mis", 32'(bus.mis), 32'h01);
    tick();
    chk("multi_irq", 32'(bus.irq), 1);
    bus.ev_sel = 16'h5555;
    tick();
    chk("evsel_keep", 32'(bus.ris), 32'hA5);
    bus.ev_sel = 16'hAAAA; bus.pin_pe = 8'hFF; rst = 1;
    tick();
    rst = 0; bus.pin_pe = 0;
    chk("midrst_ris", 32'(bus.ris), 0);
    chk("midrst_irq", 32'(bus.irq), 0);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
